// File: rtl/model_loader.sv
// model_loader: parses a LEN_LO/LEN_HI/payload/CHK byte stream, packs three payload
// bytes per 18-bit word and writes the words to model memory port A from address 0.
module model_loader #(
  parameter int MODEL_ADDR_WIDTH = 10,
  parameter int MODEL_DATA_WIDTH = 18,
  parameter int MODEL_LOC_SIZE   = 1024,
  parameter int TIMEOUT_CYCLES   = 1000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        mm_ena,
  output logic                        mm_wea,
  output logic [MODEL_ADDR_WIDTH-1:0] mm_addra,
  output logic [MODEL_DATA_WIDTH-1:0] mm_dla,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [1:0]                  err_code,
  output logic [MODEL_ADDR_WIDTH:0]   words_written
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WC_W  = MODEL_ADDR_WIDTH + 1;

  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, B0, B1, B2, WRITE, CHK, FINISH
  } state_t;

  state_t                      state_q, state_d;
  logic [15:0]                 len_q, len_d;
  logic [7:0]                  b0_q, b0_d, b1_q, b1_d, sum_q, sum_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic [WC_W-1:0]             ww_q, ww_d;
  logic                        in_ready_q, in_ready_d;
  logic                        mm_ena_q, mm_ena_d, mm_wea_q, mm_wea_d;
  logic [MODEL_ADDR_WIDTH-1:0] mm_addra_q, mm_addra_d;
  logic [MODEL_DATA_WIDTH-1:0] mm_dla_q, mm_dla_d;
  logic                        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]                  err_code_q, err_code_d;

  logic        xfer;
  logic        tmo_hit;
  logic [15:0] len_full;

  assign xfer     = in_valid && in_ready_q;
  assign len_full = {in_data, len_q[7:0]};
  assign tmo_hit  = in_ready_q && !xfer && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    sum_d      = sum_q;
    ww_d       = ww_q;
    mm_addra_d = mm_addra_q;
    mm_dla_d   = mm_dla_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    mm_ena_d   = 1'b0;
    mm_wea_d   = 1'b0;
    done_d     = 1'b0;
    // The idle counter only runs while a byte is being waited for.
    tmo_d      = (in_ready_q && !xfer) ? tmo_q + TMO_W'(1) : '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LEN_LO;
          error_d    = 1'b0;
          err_code_d = 2'd0;
          ww_d       = '0;
          sum_d      = '0;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d   = {8'h00, in_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full != 16'd0 && len_full <= 16'(MODEL_LOC_SIZE)) begin
            state_d = B0;
          end else begin
            state_d    = IDLE;
            error_d    = 1'b1;
            err_code_d = 2'd1;
          end
        end
      end
      B0: begin
        if (xfer) begin
          b0_d    = in_data;
          sum_d   = sum_q + in_data;
          state_d = B1;
        end
      end
      B1: begin
        if (xfer) begin
          b1_d    = in_data;
          sum_d   = sum_q + in_data;
          state_d = B2;
        end
      end
      B2: begin
        if (xfer) begin
          sum_d      = sum_q + in_data;
          mm_ena_d   = 1'b1;
          mm_wea_d   = 1'b1;
          mm_addra_d = ww_q[MODEL_ADDR_WIDTH-1:0];
          mm_dla_d   = MODEL_DATA_WIDTH'({in_data[1:0], b1_q, b0_q});
          state_d    = WRITE;
        end
      end
      WRITE: begin
        ww_d    = ww_q + WC_W'(1);
        state_d = ((16'(ww_q) + 16'd1) < len_q) ? B0 : CHK;
      end
      CHK: begin
        if (xfer) begin
          state_d = FINISH;
          if (in_data == sum_q) begin
            done_d = 1'b1;
          end else begin
            error_d    = 1'b1;
            err_code_d = 2'd2;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      state_d    = IDLE;
      error_d    = 1'b1;
      err_code_d = 2'd3;
    end

    in_ready_d = state_d inside {LEN_LO, LEN_HI, B0, B1, B2, CHK};
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      ww_q       <= '0;
      in_ready_q <= 1'b0;
      mm_ena_q   <= 1'b0;
      mm_wea_q   <= 1'b0;
      mm_addra_q <= '0;
      mm_dla_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      ww_q       <= ww_d;
      in_ready_q <= in_ready_d;
      mm_ena_q   <= mm_ena_d;
      mm_wea_q   <= mm_wea_d;
      mm_addra_q <= mm_addra_d;
      mm_dla_q   <= mm_dla_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign mm_ena        = mm_ena_q;
  assign mm_wea        = mm_wea_q;
  assign mm_addra      = mm_addra_q;
  assign mm_dla        = mm_dla_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_model_loader.sv
// tb_model_loader: directed frames into model_loader with a write/done monitor and
// hand-computed expected words, status codes and timing.
module tb_model_loader;

  localparam int AW  = 10;
  localparam int DW  = 18;
  localparam int LOC = 1024;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mm_ena;
  logic          mm_wea;
  logic [AW-1:0] mm_addra;
  logic [DW-1:0] mm_dla;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [AW:0]   words_written;

  always #5 clk = ~clk;

  model_loader #(
    .MODEL_ADDR_WIDTH(AW),
    .MODEL_DATA_WIDTH(DW),
    .MODEL_LOC_SIZE(LOC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mm_ena(mm_ena), .mm_wea(mm_wea), .mm_addra(mm_addra),
    .mm_dla(mm_dla), .busy(busy), .done(done), .error(error), .err_code(err_code),
    .words_written(words_written)
  );

  int            checks = 0;
  int            failures = 0;
  int            writeCount = 0;
  int            doneCount = 0;
  int            lastWait;
  int            waitTab[$];
  int            gapTab[9] = '{0, 3, 1, 5, 0, 2, 9, 4, 1};
  logic [7:0]    frame[$];
  logic [DW-1:0] wmem[LOC];
  logic [DW-1:0] fullExp[LOC];
  logic [AW-1:0] lastAddr;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Record every port-A write; the port must never accept a byte while writing.
  always @(negedge clk) begin
    if (done === 1'b1) doneCount++;
    if (mm_ena === 1'b1 || mm_wea === 1'b1) begin
      writeCount++;
      wmem[mm_addra] = mm_dla;
      lastAddr = mm_addra;
      checkOutput("in_ready_during_write", {31'd0, in_ready}, 32'd0);
      checkOutput("ena_with_wea", {30'd0, mm_ena, mm_wea}, 32'd3);
    end
  end

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    lastWait = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && lastWait < 64) begin
      @(negedge clk);
      lastWait++;
    end
    if (lastWait >= 64) checkOutput("byte_accept_bound", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input bit useGaps, input int startAt);
    waitTab.delete();
    for (int i = 0; i < frame.size(); i++) begin
      if (i == startAt) pulseStart();
      sendByte(frame[i], useGaps ? gapTab[i % 9] : 0);
      waitTab.push_back(lastWait);
    end
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic loadNominal(input logic [7:0] chk);
    frame = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h03, 8'hFF, 8'hFF, 8'hFE, chk};
  endtask

  initial begin
    int w0, d0, n, memErr;
    logic [7:0] b0, b1, b2, sum;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    checkOutput("rst_words", 32'(words_written), 32'd0);
    checkOutput("rst_mm", {12'd0, mm_ena, mm_wea, mm_dla}, 32'd0);

    // Nominal two-word load; b2=FE contributes 2'b10 to the top bits of word 1.
    $display("[TB] nominal load");
    loadNominal(8'h45);
    w0 = writeCount; d0 = doneCount;
    pulseStart();
    checkOutput("nom_busy_after_start", {31'd0, busy}, 32'd1);
    checkOutput("nom_ready_after_start", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b0, -1);
    checkOutput("nom_first_payload_wait", 32'(waitTab[2]), 32'd0);
    checkOutput("nom_byte_after_write_wait", 32'(waitTab[5]), 32'd1);
    waitIdle("nom_idle");
    checkOutput("nom_writes", 32'(writeCount - w0), 32'd2);
    checkOutput("nom_word0", 32'(wmem[0]), 32'h31234);
    checkOutput("nom_word1", 32'(wmem[1]), 32'h2FFFF);
    checkOutput("nom_done", 32'(doneCount - d0), 32'd1);
    checkOutput("nom_error", {29'd0, error, err_code}, 32'd0);
    checkOutput("nom_words", 32'(words_written), 32'd2);

    $display("[TB] bad length");
    frame = '{8'h00, 8'h00};
    w0 = writeCount;
    pulseStart();
    applyStimulus(1'b0, -1);
    checkOutput("len0_error", {29'd0, error, err_code}, 32'h5);
    checkOutput("len0_busy", {31'd0, busy}, 32'd0);
    frame = '{8'h01, 8'h04};
    pulseStart();
    checkOutput("rearm_clears_error", {29'd0, error, err_code}, 32'd0);
    applyStimulus(1'b0, -1);
    checkOutput("len1025_error", {29'd0, error, err_code}, 32'h5);
    checkOutput("len1025_busy", {31'd0, busy}, 32'd0);
    checkOutput("badlen_no_writes", 32'(writeCount - w0), 32'd0);

    $display("[TB] checksum mismatch");
    loadNominal(8'h00);
    wmem[0] = '0; wmem[1] = '0;
    w0 = writeCount; d0 = doneCount;
    pulseStart();
    applyStimulus(1'b0, -1);
    waitIdle("chk_idle");
    checkOutput("chk_writes", 32'(writeCount - w0), 32'd2);
    checkOutput("chk_word1", 32'(wmem[1]), 32'h2FFFF);
    checkOutput("chk_error", {29'd0, error, err_code}, 32'h6);
    checkOutput("chk_no_done", 32'(doneCount - d0), 32'd0);

    $display("[TB] gaps between bytes");
    loadNominal(8'h45);
    wmem[0] = '0; wmem[1] = '0;
    w0 = writeCount; d0 = doneCount;
    pulseStart();
    applyStimulus(1'b1, -1);
    waitIdle("gap_idle");
    checkOutput("gap_writes", 32'(writeCount - w0), 32'd2);
    checkOutput("gap_word0", 32'(wmem[0]), 32'h31234);
    checkOutput("gap_word1", 32'(wmem[1]), 32'h2FFFF);
    checkOutput("gap_done", 32'(doneCount - d0), 32'd1);
    checkOutput("gap_error", {29'd0, error, err_code}, 32'd0);

    $display("[TB] timeout");
    frame = '{8'h01, 8'h00, 8'h11};
    w0 = writeCount;
    pulseStart();
    applyStimulus(1'b0, -1);
    n = 0;
    while (error !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("tmo_cycles", 32'(n), 32'd16);
    checkOutput("tmo_code", {30'd0, err_code}, 32'd3);
    checkOutput("tmo_busy", {31'd0, busy}, 32'd0);
    checkOutput("tmo_no_writes", 32'(writeCount - w0), 32'd0);

    $display("[TB] reset mid-payload");
    frame = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h03, 8'hAA};
    w0 = writeCount;
    pulseStart();
    applyStimulus(1'b0, -1);
    checkOutput("rstmid_one_write", 32'(writeCount - w0), 32'd1);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); #1;
    checkOutput("rstmid_status", {27'd0, in_ready, busy, done, error, err_code[0]}, 32'd0);
    checkOutput("rstmid_words", 32'(words_written), 32'd0);
    checkOutput("rstmid_mm", {2'd0, mm_ena, mm_wea, mm_addra, mm_dla}, 32'd0);
    rst = 1'b0;
    w0 = writeCount;
    repeat (8) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    checkOutput("rstmid_no_more_writes", 32'(writeCount - w0), 32'd0);
    checkOutput("rstmid_idle_ready", {31'd0, in_ready}, 32'd0);

    // Full-size frame with a start pulse injected mid-payload, which must be ignored.
    $display("[TB] full-size load");
    frame = '{8'h00, 8'h04};
    sum = 8'h00;
    for (int i = 0; i < LOC; i++) begin
      b0 = 8'(i);
      b1 = 8'(i * 3 + 1);
      b2 = 8'(i ^ 32'h5C);
      frame.push_back(b0);
      frame.push_back(b1);
      frame.push_back(b2);
      sum = sum + b0 + b1 + b2;
      fullExp[i] = {b2[1:0], b1, b0};
    end
    frame.push_back(sum);
    w0 = writeCount; d0 = doneCount;
    pulseStart();
    applyStimulus(1'b0, 10);
    waitIdle("full_idle");
    memErr = 0;
    for (int i = 0; i < LOC; i++) if (wmem[i] !== fullExp[i]) memErr++;
    checkOutput("full_mem_errors", 32'(memErr), 32'd0);
    checkOutput("full_writes", 32'(writeCount - w0), 32'd1024);
    checkOutput("full_last_addr", 32'(lastAddr), 32'h3FF);
    checkOutput("full_words", 32'(words_written), 32'd1024);
    checkOutput("full_done", 32'(doneCount - d0), 32'd1);
    checkOutput("full_error", {29'd0, error, err_code}, 32'd0);

    $display("[TB] re-arm after done");
    loadNominal(8'h45);
    wmem[0] = '0; wmem[1] = '0;
    d0 = doneCount;
    pulseStart();
    checkOutput("rearm_words_cleared", 32'(words_written), 32'd0);
    applyStimulus(1'b0, -1);
    waitIdle("rearm_idle");
    checkOutput("rearm_word0", 32'(wmem[0]), 32'h31234);
    checkOutput("rearm_words", 32'(words_written), 32'd2);
    checkOutput("rearm_done", 32'(doneCount - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
